// File: rtl/ifetch_ctrl_pkg.sv
// Shared constants for the instruction-fetch controller: CPU widths, memory
// address width default, FSM state encoding and arbiter grant identifiers.
package ifetch_ctrl_pkg;

   localparam int IF_PC_W    = 32;
   localparam int IF_INSTR_W = 32;
   localparam int IF_ADDR_W  = 8;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_RD    = 3'd1;
   localparam logic [2:0] ST_DRAIN = 3'd2;
   localparam logic [2:0] ST_RSP   = 3'd3;
   localparam logic [2:0] ST_WR    = 3'd4;

   localparam logic GRANT_FETCH  = 1'b0;
   localparam logic GRANT_LOADER = 1'b1;

endpackage

// File: rtl/ifetch_byte_pack.sv
// Byte-serial assembly register: bytes shift in MSB-first, so the first byte
// read lands in the top byte of the instruction word.
module ifetch_byte_pack
   import ifetch_ctrl_pkg::*;
#(
   parameter int INSTR_W = IF_INSTR_W
) (
   input  logic               clk,
   input  logic               clr,
   input  logic               shift_en,
   input  logic [7:0]         din,
   output logic [INSTR_W-1:0] dout
);

   logic [INSTR_W-1:0] word;

   always_ff @(posedge clk) begin
      if (clr)
         word <= '0;
      else if (shift_en)
         word <= {word[INSTR_W-9:0], din};
   end

   assign dout = word;

endmodule

// File: rtl/ifetch_ctrl.sv
// Fetch sequencer and round-robin arbiter for a single-port byte-wide
// instruction memory shared by the CPU fetch port and the boot/debug loader.
module ifetch_ctrl
   import ifetch_ctrl_pkg::*;
#(
   parameter int ADDR_W  = IF_ADDR_W,
   parameter int INSTR_W = IF_INSTR_W,
   parameter int PC_W    = IF_PC_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               fetch_req,
   input  logic [PC_W-1:0]    fetch_pc,
   output logic               fetch_ready,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [INSTR_W-1:0] rsp_instr,
   output logic               rsp_err,
   input  logic               ld_req,
   input  logic [ADDR_W-1:0]  ld_addr,
   input  logic [7:0]         ld_data,
   output logic               ld_ack,
   output logic               mem_en,
   output logic               mem_we,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [7:0]         mem_wdata,
   input  logic [7:0]         mem_rdata
);

   logic [2:0]         state;
   logic [1:0]         cnt;
   logic               last_grant;
   logic               err_q;
   logic [ADDR_W-1:0]  base;
   logic [ADDR_W-1:0]  wr_addr;
   logic [7:0]         wr_data;
   logic               idle;
   logic               grant_fetch;
   logic               grant_ld;
   logic               fetch_bad;
   logic               pack_shift;
   logic [INSTR_W-1:0] pack_word;

   assign idle        = (state == ST_IDLE);
   // Under contention the requester that was not served last wins.
   assign grant_fetch = idle && fetch_req && (!ld_req || last_grant == GRANT_LOADER);
   assign grant_ld    = idle && ld_req && !grant_fetch;
   assign fetch_bad   = (fetch_pc[1:0] != 2'b00) || (fetch_pc[PC_W-1:ADDR_W] != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         cnt        <= 2'd0;
         last_grant <= GRANT_LOADER;
         err_q      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (grant_fetch) begin
                  last_grant <= GRANT_FETCH;
                  cnt        <= 2'd0;
                  err_q      <= fetch_bad;
                  state      <= fetch_bad ? ST_RSP : ST_RD;
               end else if (grant_ld) begin
                  last_grant <= GRANT_LOADER;
                  state      <= ST_WR;
               end
            end
            ST_RD: begin
               cnt <= cnt + 2'd1;
               if (cnt == 2'd3)
                  state <= ST_DRAIN;
            end
            ST_DRAIN: state <= ST_RSP;
            ST_RSP:   if (rsp_ready) state <= ST_IDLE;
            ST_WR:    state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (grant_fetch)
         base <= fetch_pc[ADDR_W-1:0];
      if (grant_ld) begin
         wr_addr <= ld_addr;
         wr_data <= ld_data;
      end
   end

   // Read data trails the address by one cycle, so the shift window is RD(cnt 1..3) plus DRAIN.
   assign pack_shift = ((state == ST_RD) && (cnt != 2'd0)) || (state == ST_DRAIN);

   ifetch_byte_pack #(
      .INSTR_W (INSTR_W)
   ) u_pack (
      .clk      (clk),
      .clr      (grant_fetch),
      .shift_en (pack_shift),
      .din      (mem_rdata),
      .dout     (pack_word)
   );

   assign fetch_ready = idle;
   assign rsp_valid   = !rst && (state == ST_RSP);
   assign rsp_err     = rsp_valid && err_q;
   assign rsp_instr   = (rsp_valid && !err_q) ? pack_word : '0;

   // Gating with rst keeps a reset cycle from performing or acknowledging an access.
   assign mem_en    = !rst && ((state == ST_RD) || (state == ST_WR));
   assign mem_we    = !rst && (state == ST_WR);
   assign ld_ack    = mem_we;
   assign mem_addr  = (state == ST_RD) ? base + ADDR_W'(cnt) :
                      (state == ST_WR) ? wr_addr : '0;
   assign mem_wdata = (state == ST_WR) ? wr_data : 8'h00;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Scoreboard bench for ifetch_ctrl: a byte memory model answers reads, a
// reference byte array predicts every fetch and write, a monitor compares.
module tb_ifetch_ctrl;

   typedef struct packed {
      logic [31:0] instr;
      logic        err;
      logic [3:0]  lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_req;
   logic [31:0] fetch_pc;
   logic        fetch_ready;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_instr;
   logic        rsp_err;
   logic        ld_req;
   logic [7:0]  ld_addr;
   logic [7:0]  ld_data;
   logic        ld_ack;
   logic        mem_en;
   logic        mem_we;
   logic [7:0]  mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;

   logic [7:0]  mem [256];
   logic [7:0]  ref_mem [256];
   logic        pre_we;
   logic [7:0]  pre_addr;
   logic [7:0]  pre_data;

   exp_t        exp_q [$];
   int          acc_q [$];
   logic [7:0]  addr_q [$];
   logic [15:0] wr_q [$];

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   int bp_mode = 0;
   logic prev_valid = 1'b0;

   always #5 clk = ~clk;

   ifetch_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .fetch_req   (fetch_req),
      .fetch_pc    (fetch_pc),
      .fetch_ready (fetch_ready),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_instr   (rsp_instr),
      .rsp_err     (rsp_err),
      .ld_req      (ld_req),
      .ld_addr     (ld_addr),
      .ld_data     (ld_data),
      .ld_ack      (ld_ack),
      .mem_en      (mem_en),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata)
   );

   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous single-port byte memory
   always @(posedge clk) begin
      if (pre_we)
         mem[pre_addr] <= pre_data;
      else if (mem_en && mem_we)
         mem[mem_addr] <= mem_wdata;
      if (mem_en && !mem_we)
         mem_rdata <= mem[mem_addr];
   end

   initial begin
      rsp_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         case (bp_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = ($urandom_range(0, 3) != 0);
            default: rsp_ready = 1'b0;
         endcase
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic flag(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s at cycle %0d", name, cyc);
   endtask

   // Monitor
   always @(negedge clk) begin
      if (rst) begin
         prev_valid <= 1'b0;
      end else begin
         if (mem_en && !mem_we) begin
            if (addr_q.size() == 0) flag("read_unexpected");
            else chk("read_addr", 64'(mem_addr), 64'(addr_q.pop_front()));
         end
         if (mem_we || ld_ack) begin
            if (wr_q.size() == 0) flag("write_unexpected");
            else chk("write", {mem_en, mem_we, ld_ack, mem_addr, mem_wdata},
                     {3'b111, wr_q.pop_front()});
         end
         if (rsp_valid && !prev_valid) begin
            if (acc_q.size() == 0 || exp_q.size() == 0) flag("rsp_unexpected");
            else chk("rsp_latency", 64'(cyc - acc_q.pop_front() + 1), 64'(exp_q[0].lat));
         end
         if (rsp_valid && exp_q.size() != 0) begin
            chk("rsp_data", {rsp_instr, rsp_err, fetch_ready, mem_en},
                {exp_q[0].instr, exp_q[0].err, 2'b00});
            if (rsp_ready) void'(exp_q.pop_front());
         end
         prev_valid <= rsp_valid;
      end
   end

   task automatic preload(input logic [7:0] a, input logic [7:0] d);
      ref_mem[a] = d;
      pre_addr   = a;
      pre_data   = d;
      pre_we     = 1'b1;
      @(posedge clk);
      #1;
      pre_we     = 1'b0;
   endtask

   task automatic do_fetch(input logic [31:0] pc, input int nrd, input bit want_rsp,
                           output int t_acc);
      exp_t       e;
      logic       bad;
      logic       rdy;
      logic [7:0] a;
      a       = pc[7:0];
      bad     = (pc[1:0] != 2'b00) || (pc[31:8] != 24'd0);
      e.err   = bad;
      e.lat   = bad ? 4'd1 : 4'd6;
      e.instr = bad ? 32'd0 : {ref_mem[a], ref_mem[8'(a + 1)], ref_mem[8'(a + 2)], ref_mem[8'(a + 3)]};
      if (want_rsp) exp_q.push_back(e);
      if (!bad) for (int k = 0; k < nrd; k++) addr_q.push_back(8'(a + k));
      fetch_pc  = pc;
      fetch_req = 1'b1;
      t_acc     = -1;
      for (int i = 0; i < 300 && t_acc < 0; i++) begin
         @(negedge clk);
         rdy = fetch_ready;
         @(posedge clk);
         #1;
         if (rdy && ((mem_en && !mem_we) || rsp_valid)) t_acc = cyc;
      end
      fetch_req = 1'b0;
      if (t_acc < 0) flag("fetch_grant_timeout");
      else if (want_rsp) acc_q.push_back(t_acc);
   endtask

   task automatic do_load(input logic [7:0] a, input logic [7:0] d, output int t_acc);
      logic rdy;
      wr_q.push_back({a, d});
      ref_mem[a] = d;
      ld_addr = a;
      ld_data = d;
      ld_req  = 1'b1;
      t_acc   = -1;
      for (int i = 0; i < 300 && t_acc < 0; i++) begin
         @(negedge clk);
         rdy = fetch_ready;
         @(posedge clk);
         #1;
         if (rdy && mem_we) t_acc = cyc;
      end
      ld_req = 1'b0;
      if (t_acc < 0) flag("load_grant_timeout");
   endtask

   task automatic wait_idle();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 500 && !done; i++) begin
         @(posedge clk);
         #1;
         done = (exp_q.size() == 0) && (addr_q.size() == 0) && (wr_q.size() == 0) &&
                fetch_ready && !rsp_valid;
      end
      if (!done) flag("drain_timeout");
   endtask

   initial begin
      int          tf1, tf2, tl, t;
      logic [31:0] r;
      logic [31:0] pc;
      rst       = 1'b1;
      fetch_req = 1'b0;
      fetch_pc  = 32'd0;
      ld_req    = 1'b0;
      ld_addr   = 8'd0;
      ld_data   = 8'd0;
      pre_we    = 1'b0;
      pre_addr  = 8'd0;
      pre_data  = 8'd0;

      for (int i = 0; i < 256; i++) begin
         r = $urandom;
         preload(8'(i), r[7:0]);
      end
      preload(8'h10, 8'h8C); preload(8'h11, 8'h01); preload(8'h12, 8'h00); preload(8'h13, 8'h04);
      preload(8'hFC, 8'hDE); preload(8'hFD, 8'hAD); preload(8'hFE, 8'hBE); preload(8'hFF, 8'hEF);
      rst = 1'b0;

      chk("reset_ready", 64'(fetch_ready), 64'd1);
      chk("reset_rsp", {rsp_valid, rsp_err, rsp_instr}, 64'd0);
      chk("reset_ack", 64'(ld_ack), 64'd0);
      chk("reset_mem", {mem_en, mem_we, mem_addr, mem_wdata}, 64'd0);

      // Both requesters from reset: fetch, loader, fetch
      fork
         begin
            do_fetch(32'h10, 4, 1'b1, tf1);
            do_fetch(32'h20, 4, 1'b1, tf2);
         end
         do_load(8'h20, 8'hAB, tl);
      join
      chk("grant_order", {(tf1 > 0 && tf1 < tl), (tl < tf2)}, 64'b11);
      wait_idle();

      do_fetch(32'h11, 0, 1'b1, t);
      do_fetch(32'h100, 0, 1'b1, t);
      wait_idle();

      do_fetch(32'hFC, 4, 1'b1, t);
      wait_idle();

      // Response held under back-pressure
      bp_mode = 2;
      do_fetch(32'h10, 4, 1'b1, t);
      for (int i = 0; i < 50 && !rsp_valid; i++) begin
         @(posedge clk);
         #1;
      end
      if (!rsp_valid) flag("bp_rsp_timeout");
      repeat (5) @(posedge clk);
      #1;
      chk("bp_held", {rsp_valid, fetch_ready}, 64'b10);
      bp_mode = 0;
      @(posedge clk);
      #1;
      chk("bp_release", {rsp_valid, fetch_ready}, 64'b01);
      wait_idle();

      // Reset during the read burst
      do_fetch(32'h40, 2, 1'b0, t);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("reset_mid", {fetch_ready, rsp_valid, mem_en}, 64'b100);
      do_fetch(32'h40, 4, 1'b1, t);
      wait_idle();

      bp_mode = 1;
      for (int n = 0; n < 40; n++) begin
         r = $urandom;
         case ($urandom_range(0, 9))
            0, 1, 2: do_load(r[7:0], r[15:8], t);
            3:       begin pc = {24'd0, r[7:2], 2'b01 + 2'(r[9:8] % 3)}; do_fetch(pc, 4, 1'b1, t); end
            4:       begin pc = {r[31:8] | 24'd1, r[7:2], 2'b00}; do_fetch(pc, 4, 1'b1, t); end
            default: begin pc = {24'd0, r[7:2], 2'b00}; do_fetch(pc, 4, 1'b1, t); end
         endcase
      end
      wait_idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
